// File: rtl/joypad_emu.sv
// NES pad responder: emulates the pad's parallel-in/serial-out shift register,
// fed by synchronised, debounced board buttons with optional A/B turbo.
module joypad_emu #(
  parameter int DEBOUNCE_CYCLES   = 500000,
  parameter int TURBO_HALF_PERIOD = 1666666
) (
  input  logic       clk_in,
  input  logic       nrst_in,
  input  logic [7:0] btn_in,
  input  logic [1:0] turbo_en_in,
  input  logic       jp_latch_in,
  input  logic       jp_clk_in,
  output logic       jp_data_out,
  output logic [7:0] btn_state_out,
  output logic [3:0] bit_cnt_out
);

  // state | meaning
  // IDLE  | after reset, waiting for the first latch
  // LOAD  | latch high, shreg tracks the effective buttons every cycle
  // SHIFT | latch released, each host clock rise shifts one button out
  // DONE  | eight bits shifted, further rises shift in 1s, count saturates
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_DONE} state_t;

  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam int TW = $clog2(TURBO_HALF_PERIOD) + 1;

  logic          latch_s1, latch_s;
  logic          hclk_s1, hclk_s, hclk_d;
  logic [7:0]    btn_s1, btn_s, btn_prev;
  logic [DW-1:0] deb_cnt;
  logic [TW-1:0] turbo_cnt;
  logic          turbo_phase;
  logic          deb_tick, turbo_tick, clk_rise;
  logic [7:0]    stable, eff;
  state_t        state, state_nxt;
  logic [7:0]    shreg, shreg_nxt;
  logic [3:0]    cnt_nxt;

  always_ff @(posedge clk_in or negedge nrst_in) begin
    if (!nrst_in) begin
      latch_s1 <= 1'b0;
      latch_s  <= 1'b0;
      hclk_s1  <= 1'b0;
      hclk_s   <= 1'b0;
      hclk_d   <= 1'b0;
      btn_s1   <= '0;
      btn_s    <= '0;
    end else begin
      latch_s1 <= jp_latch_in;
      latch_s  <= latch_s1;
      hclk_s1  <= jp_clk_in;
      hclk_s   <= hclk_s1;
      hclk_d   <= hclk_s;
      btn_s1   <= btn_in;
      btn_s    <= btn_s1;
    end
  end

  assign clk_rise   = hclk_s & ~hclk_d;
  assign deb_tick   = (deb_cnt == DW'(DEBOUNCE_CYCLES - 1));
  assign turbo_tick = (turbo_cnt == TW'(TURBO_HALF_PERIOD - 1));
  // A bit is accepted only if it read the same on two consecutive ticks
  assign stable     = ~(btn_s ^ btn_prev);

  always_ff @(posedge clk_in or negedge nrst_in) begin
    if (!nrst_in) begin
      deb_cnt       <= '0;
      btn_prev      <= '0;
      btn_state_out <= '0;
    end else begin
      deb_cnt <= deb_tick ? '0 : deb_cnt + 1'b1;
      if (deb_tick) begin
        btn_prev      <= btn_s;
        btn_state_out <= (btn_state_out & ~stable) | (btn_s & stable);
      end
    end
  end

  always_ff @(posedge clk_in or negedge nrst_in) begin
    if (!nrst_in) begin
      turbo_cnt   <= '0;
      turbo_phase <= 1'b1;
    end else begin
      turbo_cnt <= turbo_tick ? '0 : turbo_cnt + 1'b1;
      if (turbo_tick) turbo_phase <= ~turbo_phase;
    end
  end

  always_comb begin
    eff    = btn_state_out;
    eff[0] = btn_state_out[0] & (turbo_phase | ~turbo_en_in[0]);
    eff[1] = btn_state_out[1] & (turbo_phase | ~turbo_en_in[1]);
  end

  always_comb begin
    state_nxt = state;
    shreg_nxt = shreg;
    cnt_nxt   = bit_cnt_out;
    if (latch_s) begin
      state_nxt = S_LOAD;
      shreg_nxt = eff;
      cnt_nxt   = 4'd0;
    end else begin
      case (state)
        S_LOAD: state_nxt = S_SHIFT;
        S_SHIFT: begin
          if (clk_rise) begin
            shreg_nxt = {1'b1, shreg[7:1]};
            cnt_nxt   = bit_cnt_out + 4'd1;
            if (bit_cnt_out == 4'd7) state_nxt = S_DONE;
          end
        end
        S_DONE: begin
          if (clk_rise) shreg_nxt = {1'b1, shreg[7:1]};
        end
        default: ;
      endcase
    end
  end

  // Pin is registered from the next shreg value so a host edge shows up 3 cycles later
  always_ff @(posedge clk_in or negedge nrst_in) begin
    if (!nrst_in) begin
      state       <= S_IDLE;
      shreg       <= '0;
      bit_cnt_out <= '0;
      jp_data_out <= 1'b1;
    end else begin
      state       <= state_nxt;
      shreg       <= shreg_nxt;
      bit_cnt_out <= cnt_nxt;
      jp_data_out <= ~shreg_nxt[0];
    end
  end

endmodule
